// File: rtl/flash_pkg.sv
// Shared flash-side definitions: bus widths and the word-reader FSM state encoding.
// Used by flash_word_reader and the sample fetcher.
package flash_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int FLASH_DATA_W = 32;

    localparam logic [3:0] FLASH_BYTEENABLE_ALL = 4'hF;

    typedef enum logic [1:0] {
        FLASH_IDLE      = 2'd0,
        FLASH_ISSUE     = 2'd1,
        FLASH_WAIT_DATA = 2'd2,
        FLASH_RESPOND   = 2'd3
    } flash_state_e;

endpackage

// File: rtl/flash_word_reader.sv
// Single-word flash reader with a one-word cache in front of an Avalon-MM read master.
// Optional miss-read abort is enabled with the FLASH_READ_TIMEOUT_EN macro.
module flash_word_reader
    import flash_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    fetch_clock,
    input  logic                    reset,
    input  logic                    req,
    input  logic [FLASH_ADDR_W-1:0] req_addr,
    input  logic                    cache_flush,
    output logic                    rsp_valid,
    output logic [FLASH_DATA_W-1:0] rsp_data,
    output logic                    busy,
    output logic                    flash_mem_read,
    output logic [FLASH_ADDR_W-1:0] flash_mem_address,
    output logic [3:0]              flash_mem_byteenable,
    input  logic                    flash_mem_waitrequest,
    input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
    input  logic                    flash_mem_readdatavalid,
    output logic                    timeout_err
);

    flash_state_e            state_q, state_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [FLASH_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [FLASH_ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [FLASH_DATA_W-1:0] cache_data_q, cache_data_d;
    logic                    cache_valid_q, cache_valid_d;
    logic                    read_q, read_d;
    logic                    busy_q, busy_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    hit_s;
    logic                    capture_s;

`ifdef FLASH_READ_TIMEOUT_EN
    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    assign hit_s = cache_valid_q && (req_addr == cache_addr_q) && !cache_flush;

    // Next-state, datapath and cache update
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rsp_data_d    = rsp_data_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        cache_valid_d = cache_valid_q;
        capture_s     = 1'b0;

        case (state_q)
            FLASH_IDLE: begin
                if (req && hit_s) begin
                    state_d    = FLASH_RESPOND;
                    rsp_data_d = cache_data_q;
                end else if (req) begin
                    state_d = FLASH_ISSUE;
                    addr_d  = req_addr;
                end else begin
                    state_d = FLASH_IDLE;
                end
            end
            FLASH_ISSUE: begin
                // Data may already accompany the accepting cycle.
                if (!flash_mem_waitrequest) begin
                    state_d   = FLASH_WAIT_DATA;
                    capture_s = flash_mem_readdatavalid;
                end else begin
                    state_d = FLASH_ISSUE;
                end
            end
            FLASH_WAIT_DATA: begin
                capture_s = flash_mem_readdatavalid;
            end
            FLASH_RESPOND: begin
                state_d = FLASH_IDLE;
            end
            default: begin
                state_d = FLASH_IDLE;
            end
        endcase

        if (capture_s) begin
            state_d       = FLASH_RESPOND;
            rsp_data_d    = flash_mem_readdata;
            cache_addr_d  = addr_q;
            cache_data_d  = flash_mem_readdata;
            cache_valid_d = 1'b1;
        end else begin
            cache_valid_d = cache_valid_q;
        end

`ifdef FLASH_READ_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == FLASH_IDLE && state_d == FLASH_ISSUE) begin
            tmo_cnt_d = {TMO_W{1'b0}};
        end else if ((state_q == FLASH_ISSUE || state_q == FLASH_WAIT_DATA) && !capture_s) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (tmo_cnt_d == TMO_LIMIT) begin
                state_d       = FLASH_RESPOND;
                rsp_data_d    = {FLASH_DATA_W{1'b0}};
                timeout_err_d = 1'b1;
            end else begin
                timeout_err_d = timeout_err_q;
            end
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
`endif

        // A flush wins over a same-cycle capture.
        if (cache_flush) begin
            cache_valid_d = 1'b0;
        end else begin
            cache_valid_d = cache_valid_d;
        end

        read_d      = (state_d == FLASH_ISSUE);
        busy_d      = (state_d != FLASH_IDLE);
        rsp_valid_d = (state_d == FLASH_RESPOND);
    end

    // State and output registers
    always_ff @(posedge fetch_clock) begin
        if (reset) begin
            state_q       <= FLASH_IDLE;
            addr_q        <= {FLASH_ADDR_W{1'b0}};
            rsp_data_q    <= {FLASH_DATA_W{1'b0}};
            cache_addr_q  <= {FLASH_ADDR_W{1'b0}};
            cache_data_q  <= {FLASH_DATA_W{1'b0}};
            cache_valid_q <= 1'b0;
            read_q        <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rsp_data_q    <= rsp_data_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            cache_valid_q <= cache_valid_d;
            read_q        <= read_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

`ifdef FLASH_READ_TIMEOUT_EN
    // Miss-read budget counter and sticky abort flag
    always_ff @(posedge fetch_clock) begin
        if (reset) begin
            tmo_cnt_q     <= {TMO_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = 32'(TIMEOUT_CYCLES);
    assign timeout_err          = 1'b0;
`endif

    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign busy                 = busy_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = FLASH_BYTEENABLE_ALL;

endmodule

// File: tb/tb_flash_word_reader.sv
// Directed, scoreboard-checked bench for flash_word_reader with a small Avalon-MM slave model.
// Build with FLASH_READ_TIMEOUT_EN defined to exercise the abort path.
module tb_flash_word_reader;

    logic        fetch_clock = 1'b0;
    logic        reset;
    logic        req;
    logic [22:0] req_addr;
    logic        cache_flush;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    // slave model and monitor state
    int          stall_left  = 0;
    int          dv_delay    = 1;
    int          dv_wait     = 0;
    bit          dv_pending  = 1'b0;
    bit          force_dv    = 1'b0;
    logic [31:0] slave_data  = 32'h0;
    logic [22:0] cur_addr    = 23'h0;
    int          read_cycles = 0;
    int          addr_bad    = 0;
    int          rsp_count   = 0;
    logic [31:0] exp_q[$];

    flash_word_reader #(.TIMEOUT_CYCLES(8)) dut (
        .fetch_clock             (fetch_clock),
        .reset                   (reset),
        .req                     (req),
        .req_addr                (req_addr),
        .cache_flush             (cache_flush),
        .rsp_valid               (rsp_valid),
        .rsp_data                (rsp_data),
        .busy                    (busy),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .timeout_err             (timeout_err)
    );

    always #5 fetch_clock = ~fetch_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, then slave inputs updated.
    task automatic tick();
        @(posedge fetch_clock);
        #1;
        if (rsp_valid) rsp_count++;
        if (flash_mem_read) begin
            read_cycles++;
            if (flash_mem_address !== cur_addr) addr_bad++;
        end
        flash_mem_readdata      = slave_data;
        flash_mem_readdatavalid = force_dv;
        force_dv                = 1'b0;
        if (dv_pending) begin
            if (dv_wait == 0) begin
                flash_mem_readdatavalid = 1'b1;
                dv_pending              = 1'b0;
            end else begin
                dv_wait--;
            end
        end
        if (flash_mem_read) begin
            if (stall_left > 0) begin
                flash_mem_waitrequest = 1'b1;
                stall_left--;
            end else begin
                flash_mem_waitrequest = 1'b0;
                if (dv_delay == 0) begin
                    flash_mem_readdatavalid = 1'b1;
                end else begin
                    dv_pending = 1'b1;
                    dv_wait    = dv_delay - 1;
                end
            end
        end else begin
            flash_mem_waitrequest = 1'b0;
        end
    endtask

    task automatic run_req(input string tag, input logic [22:0] addr, input logic flush,
                           input logic [31:0] exp_data, input int exp_lat, input int exp_reads);
        int          lat;
        int          rsp_before;
        logic [31:0] want;
        exp_q.push_back(exp_data);
        read_cycles = 0;
        addr_bad    = 0;
        cur_addr    = addr;
        rsp_before  = rsp_count;
        req         = 1'b1;
        req_addr    = addr;
        cache_flush = flush;
        tick();
        req         = 1'b0;
        cache_flush = 1'b0;
        lat         = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        if (rsp_valid) begin
            want = exp_q.pop_front();
            check({tag, "_data"}, rsp_data, want);
            check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        end else begin
            exp_q.delete();
        end
        tick();
        check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_read_cycles"}, 32'(read_cycles), 32'(exp_reads));
        check({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
        check({tag, "_rsp_count"}, 32'(rsp_count - rsp_before), 32'd1);
    endtask

    initial begin
        int          rsp_before;
        logic [31:0] want;

        reset                   = 1'b1;
        req                     = 1'b0;
        req_addr                = 23'h0;
        cache_flush             = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdata      = 32'h0;
        flash_mem_readdatavalid = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(flash_mem_read), 32'd0);
        check("rst_addr", 32'(flash_mem_address), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("byteenable", 32'(flash_mem_byteenable), 32'hF);
        reset = 1'b0;
        tick();

        // basic miss, minimum latency
        slave_data = 32'hA1B2C3D4; stall_left = 0; dv_delay = 1;
        run_req("miss_basic", 23'h000010, 1'b0, 32'hA1B2C3D4, 3, 1);

        // hit on the cached word
        slave_data = 32'hFFFF0000;
        run_req("hit", 23'h000010, 1'b0, 32'hA1B2C3D4, 1, 0);

        // same address with flush in the request cycle, slave stalls 5 cycles
        slave_data = 32'h55AA1234; stall_left = 5;
        run_req("flush_stall", 23'h000010, 1'b1, 32'h55AA1234, 8, 6);
        run_req("hit_refill", 23'h000010, 1'b0, 32'h55AA1234, 1, 0);

        // data alongside the accepting ISSUE cycle, top address
        slave_data = 32'hDEADBEEF; dv_delay = 0;
        run_req("issue_data", 23'h7FFFFF, 1'b0, 32'hDEADBEEF, 2, 1);

        // standalone flush while idle
        cache_flush = 1'b1;
        tick();
        cache_flush = 1'b0;
        slave_data = 32'h0F0F0F0F; dv_delay = 1;
        run_req("flush_idle", 23'h7FFFFF, 1'b0, 32'h0F0F0F0F, 3, 1);

        // requests while busy are dropped
        slave_data = 32'h11111111; stall_left = 2;
        read_cycles = 0; addr_bad = 0; cur_addr = 23'h000123; rsp_before = rsp_count;
        exp_q.push_back(32'h11111111);
        req = 1'b1; req_addr = 23'h000123;
        tick();
        req_addr = 23'h000456;
        tick();
        tick();
        tick();
        req = 1'b0;
        tick();
        check("busy_req_rsp", 32'(rsp_valid), 32'd1);
        want = exp_q.pop_front();
        check("busy_req_data", rsp_data, want);
        repeat (4) tick();
        check("busy_req_count", 32'(rsp_count - rsp_before), 32'd1);
        check("busy_req_idle", 32'(busy), 32'd0);
        check("busy_req_reads", 32'(read_cycles), 32'd3);
        check("busy_req_addr", 32'(addr_bad), 32'd0);

        // readdatavalid while idle is ignored
        slave_data = 32'hBAD0BAD0; force_dv = 1'b1; rsp_before = rsp_count;
        tick();
        tick();
        check("idle_dv_rsp", 32'(rsp_count - rsp_before), 32'd0);
        check("idle_dv_data", rsp_data, 32'h11111111);
        check("idle_dv_busy", 32'(busy), 32'd0);
        slave_data = 32'h22222222;
        run_req("hit_123", 23'h000123, 1'b0, 32'h11111111, 1, 0);

        // reset while waiting for data; data arrives after reset
        slave_data = 32'h99999999; dv_delay = 2; cur_addr = 23'h000020;
        req = 1'b1; req_addr = 23'h000020;
        tick();
        req = 1'b0;
        tick();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_read", 32'(flash_mem_read), 32'd0);
        rsp_before = rsp_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_dv_present", 32'(flash_mem_readdatavalid), 32'd1);
        tick();
        tick();
        check("rst_wait_no_rsp", 32'(rsp_count - rsp_before), 32'd0);
        check("rst_wait_idle", 32'(busy), 32'd0);
        check("rst_wait_data", rsp_data, 32'd0);
        slave_data = 32'h13572468; dv_delay = 1;
        run_req("post_rst_miss", 23'h000123, 1'b0, 32'h13572468, 3, 1);

        // waitrequest stuck high
        slave_data = 32'hFFFFFFFF; stall_left = 1000;
`ifdef FLASH_READ_TIMEOUT_EN
        run_req("timeout", 23'h000040, 1'b0, 32'h00000000, 9, 8);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        repeat (3) tick();
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);
`else
        rsp_before = rsp_count; cur_addr = 23'h000040;
        req = 1'b1; req_addr = 23'h000040;
        tick();
        req = 1'b0;
        repeat (40) tick();
        check("stuck_no_rsp", 32'(rsp_count - rsp_before), 32'd0);
        check("stuck_busy", 32'(busy), 32'd1);
        check("stuck_read", 32'(flash_mem_read), 32'd1);
        check("stuck_no_err", 32'(timeout_err), 32'd0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall_left = 0; dv_pending = 1'b0;
        check("final_rst_err", 32'(timeout_err), 32'd0);
        check("final_rst_read", 32'(flash_mem_read), 32'd0);
        check("final_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flash_word_reader.md
FLASH_WORD_READER -- requirements
Module: flash_word_reader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: miss-read cycle budget before abort (used only with FLASH_READ_TIMEOUT_EN).
REQ-002 Port fetch_clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port req, input, 1: word-read request from the sample fetcher.
REQ-005 Port req_addr, input, 23: word address of the request.
REQ-006 Port cache_flush, input, 1: invalidates the one-word cache.
REQ-007 Port rsp_valid, output, 1: one-cycle pulse; rsp_data valid.
REQ-008 Port rsp_data, output, 32: returned flash word, held until the next response.
REQ-009 Port busy, output, 1: high in every state except IDLE.
REQ-010 Port flash_mem_read, output, 1: Avalon-MM read strobe.
REQ-011 Port flash_mem_address, output, 23: Avalon-MM word address.
REQ-012 Port flash_mem_byteenable, output, 4: constant 4'hF.
REQ-013 Port flash_mem_waitrequest, input, 1: slave stall.
REQ-014 Port flash_mem_readdata, input, 32: slave read data.
REQ-015 Port flash_mem_readdatavalid, input, 1: slave data strobe.
REQ-016 Port timeout_err, output, 1: sticky abort flag.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_DATA and RESPOND; rsp_valid = (state==RESPOND).
REQ-018 In IDLE with req=1: a hit (cache_valid, req_addr==cache_addr, cache_flush=0) SHALL go to RESPOND with rsp_data=cache_data and no flash access; hit latency is 1 cycle.
REQ-019 In IDLE with req=1 on a miss: req_addr SHALL be latched into flash_mem_address and the FSM SHALL go to ISSUE.
REQ-020 flash_mem_read SHALL be 1 only in ISSUE; flash_mem_address SHALL be stable throughout ISSUE; exit to WAIT_DATA on the first cycle with waitrequest=0.
REQ-021 readdatavalid=1 in WAIT_DATA, or in ISSUE together with waitrequest=0, SHALL capture readdata into rsp_data and the cache (cache_addr=flash_mem_address, cache_valid=1) and go to RESPOND.
REQ-022 Minimum miss latency: req sampled cycle 0, ISSUE cycle 1 (waitrequest=0), data cycle 2, rsp_valid cycle 3.
REQ-023 RESPOND SHALL last exactly one cycle, then IDLE; req outside IDLE SHALL be ignored (not queued).
REQ-024 readdatavalid in IDLE or RESPOND SHALL be ignored.
REQ-025 cache_flush SHALL clear cache_valid in any state; flush together with a capture leaves cache_valid=0.

Reset
REQ-026 Reset SHALL force IDLE, flash_mem_read=0, flash_mem_address=0, rsp_valid=0, rsp_data=0, cache_valid=0, timeout_err=0, timeout counter=0, in any state including mid-read; data arriving after reset SHALL be ignored.

Configuration
REQ-027 With FLASH_READ_TIMEOUT_EN defined, a counter SHALL clear on IDLE->ISSUE, increment each ISSUE/WAIT_DATA cycle, and on reaching TIMEOUT_CYCLES force RESPOND with rsp_data=0, no cache update, flash_mem_read=0, timeout_err=1 until reset.
REQ-028 Without FLASH_READ_TIMEOUT_EN, no counter SHALL exist, reads wait indefinitely, and timeout_err is constant 0.

Structure
REQ-029 Package flash_pkg SHALL hold FLASH_ADDR_W=23, FLASH_DATA_W=32 and the FSM state enum; the same package serves the sample fetcher.
REQ-030 The block SHALL be one flat module with no sub-modules.

Verification
REQ-031 Miss, waitrequest=0, data 1 cycle later: req_addr=0x000010, readdata=0xA1B2C3D4 -> rsp_valid at cycle 3, rsp_data=0xA1B2C3D4, one read strobe.
REQ-032 Stall: waitrequest high 5 cycles -> flash_mem_read and address 0x000010 held 6 cycles, then a single response.
REQ-033 Hit: repeat req 0x000010 -> rsp_valid next cycle, data 0xA1B2C3D4, flash_mem_read stays 0; with cache_flush in same cycle -> full miss read.
REQ-034 Reset asserted in WAIT_DATA, readdatavalid the next cycle -> IDLE, rsp_valid never asserts, cache_valid=0.
REQ-035 FLASH_READ_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck high -> rsp_valid with rsp_data=0 after 8 busy cycles, timeout_err=1 until reset; without macro -> no response, timeout_err=0.
